// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the scan-out slice.
package vga_pkg;

    // 640x480@60 horizontal timing in pixels
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    // 640x480@60 vertical timing in lines
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int CNT_W = 10;

    // Both syncs are active-low for this mode
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [11:0]      rgb444_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // One entry of the blank/sync alignment delay line
    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
    } tmg_t;

    localparam tmg_t TMG_RST = '{valid: 1'b0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE};

endpackage

// File: rtl/vga_scan_out_if.sv
// Bus between the scan-out block and the address/ROM stage plus the VGA pins.
interface vga_scan_out_if;
    import vga_pkg::*;

    rgb444_t    pixel_in;
    cnt_t       h_cnt;
    cnt_t       v_cnt;
    logic       valid;
    logic       pix_tick;
    logic       frame_start;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       hsync;
    logic       vsync;

    modport master (
        input  pixel_in,
        output h_cnt, v_cnt, valid, pix_tick, frame_start,
        output vga_r, vga_g, vga_b, hsync, vsync
    );

    modport slave (
        output pixel_in,
        input  h_cnt, v_cnt, valid, pix_tick, frame_start,
        input  vga_r, vga_g, vga_b, hsync, vsync
    );
endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-rate divider, h/v scan counters and raw blank/sync decode.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VIS_PX  = vga_pkg::H_VIS,
    parameter int H_FP_PX   = vga_pkg::H_FP,
    parameter int H_SYNC_PX = vga_pkg::H_SYNC,
    parameter int H_BP_PX   = vga_pkg::H_BP,
    parameter int V_VIS_LN  = vga_pkg::V_VIS,
    parameter int V_FP_LN   = vga_pkg::V_FP,
    parameter int V_SYNC_LN = vga_pkg::V_SYNC,
    parameter int V_BP_LN   = vga_pkg::V_BP
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic frame_start,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic valid,
    output logic hs_raw,
    output logic vs_raw
);
    localparam int H_TOT = H_VIS_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;
    localparam int V_TOT = V_VIS_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam cnt_t H_LAST  = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOT - 1);
    localparam cnt_t H_VIS_C = cnt_t'(H_VIS_PX);
    localparam cnt_t V_VIS_C = cnt_t'(V_VIS_LN);
    localparam cnt_t HS_BEG  = cnt_t'(H_VIS_PX + H_FP_PX);
    localparam cnt_t HS_END  = cnt_t'(H_VIS_PX + H_FP_PX + H_SYNC_PX);
    localparam cnt_t VS_BEG  = cnt_t'(V_VIS_LN + V_FP_LN);
    localparam cnt_t VS_END  = cnt_t'(V_VIS_LN + V_FP_LN + V_SYNC_LN);

    logic [DIV_W-1:0] div_q, div_d;
    cnt_t             h_q, h_d, v_q, v_d;
    logic             tick_q, tick_d;
    logic             fs_q, fs_d;

    // Next-state: divider, counters, and tick/frame strobes computed one clk early
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (tick_q) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        // tick_q mirrors div_q==DIV_LAST; fs is judged on the counters of that same clk
        tick_d = (div_d == DIV_LAST);
        fs_d   = tick_d && (h_d == H_LAST) && (v_d == V_LAST);
    end

    // Counter and strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            tick_q <= tick_d;
            fs_q   <= fs_d;
        end
    end

    // Undelayed visible-area and sync decode of the current counter position
    always_comb begin
        valid = (h_q < H_VIS_C) && (v_q < V_VIS_C);
        if ((h_q >= HS_BEG) && (h_q < HS_END)) begin
            hs_raw = SYNC_ACTIVE;
        end else begin
            hs_raw = ~SYNC_ACTIVE;
        end
        if ((v_q >= VS_BEG) && (v_q < VS_END)) begin
            vs_raw = SYNC_ACTIVE;
        end else begin
            vs_raw = ~SYNC_ACTIVE;
        end
    end

    assign tick        = tick_q;
    assign frame_start = fs_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: counters for address generation, pixel/sync re-alignment, pin registers.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RD_LATENCY = 1,
    parameter int H_VIS_PX   = vga_pkg::H_VIS,
    parameter int H_FP_PX    = vga_pkg::H_FP,
    parameter int H_SYNC_PX  = vga_pkg::H_SYNC,
    parameter int H_BP_PX    = vga_pkg::H_BP,
    parameter int V_VIS_LN   = vga_pkg::V_VIS,
    parameter int V_FP_LN    = vga_pkg::V_FP,
    parameter int V_SYNC_LN  = vga_pkg::V_SYNC,
    parameter int V_BP_LN    = vga_pkg::V_BP
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_out_if.master bus
);
    logic tick_s, fs_s, valid_s, hs_raw_s, vs_raw_s;
    cnt_t h_s, v_s;

    vga_sync_counter #(
        .CLK_DIV  (CLK_DIV),
        .H_VIS_PX (H_VIS_PX),
        .H_FP_PX  (H_FP_PX),
        .H_SYNC_PX(H_SYNC_PX),
        .H_BP_PX  (H_BP_PX),
        .V_VIS_LN (V_VIS_LN),
        .V_FP_LN  (V_FP_LN),
        .V_SYNC_LN(V_SYNC_LN),
        .V_BP_LN  (V_BP_LN)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick_s),
        .frame_start(fs_s),
        .h_cnt      (h_s),
        .v_cnt      (v_s),
        .valid      (valid_s),
        .hs_raw     (hs_raw_s),
        .vs_raw     (vs_raw_s)
    );

    // Blank/sync travel RD_LATENCY ticks to meet the ROM data for the same address
    tmg_t    dly_q [RD_LATENCY];
    tmg_t    dly_d [RD_LATENCY];
    rgb444_t rgb_q, rgb_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;

    // Advance the delay line and load the pin registers only on a pixel tick
    always_comb begin
        dly_d   = dly_q;
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (tick_s) begin
            dly_d[0] = '{valid: valid_s, hs: hs_raw_s, vs: vs_raw_s};
            for (int i = 1; i < RD_LATENCY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
            if (dly_q[RD_LATENCY-1].valid) begin
                rgb_d = bus.pixel_in;
            end else begin
                rgb_d = 12'h000;
            end
            hsync_d = dly_q[RD_LATENCY-1].hs;
            vsync_d = dly_q[RD_LATENCY-1].vs;
        end else begin
            dly_d = dly_q;
        end
    end

    // Delay line and output pin registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                dly_q[i] <= TMG_RST;
            end
            rgb_q   <= 12'h000;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
        end else begin
            dly_q   <= dly_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign bus.h_cnt       = h_s;
    assign bus.v_cnt       = v_s;
    assign bus.valid       = valid_s;
    assign bus.pix_tick    = tick_s;
    assign bus.frame_start = fs_s;
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
endmodule
